// File: rtl/io_timer_intr_if.sv
// CPU-side IO bus and interrupt handshake for the io_timer_intr block.
// The CPU drives through the master modport; the timer sits on the slave modport.
interface io_timer_intr_if;
  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_address;
  logic [31:0] io_d_in;
  logic [31:0] io_out;
  logic        intr;
  logic        inta;

  modport master (
    output io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    input  io_out, intr
  );

  modport slave (
    input  io_cs, io_rd, io_wr, io_address, io_d_in, inta,
    output io_out, intr
  );
endinterface

// File: rtl/io_timer_intr.sv
// Down-counting IO timer with a registered intr/inta request-acknowledge handshake.
// Optional feature macro IO_TIMER_PRESCALE_EN adds an 8-bit prescaler at offset 0x10.
module io_timer_intr (
  input  logic            clk,
  input  logic            reset,
  io_timer_intr_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } irq_state_t;

  irq_state_t  state_p1;
  irq_state_t  state_nxt;

  logic        en_p1;
  logic        auto_p1;
  logic [31:0] period_p1;
  logic [31:0] count_p1;
  logic        ovf_p1;
  logic        evt_p1;

  logic        wr_en;
  logic        rd_en;
  logic [2:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_period;
  logic        wr_status;
  logic        en_rise;
  logic        tick;
  logic        count_run;
  logic        timer_evt;
  logic        pend;
  logic [31:0] prescale_rd;
  logic [31:0] rdata;
  logic        unused_addr;

  assign wr_en     = bus.io_cs & bus.io_wr;
  assign rd_en     = bus.io_cs & bus.io_rd;
  assign reg_sel   = bus.io_address[4:2];
  assign wr_ctrl   = wr_en && (reg_sel == 3'd0);
  assign wr_period = wr_en && (reg_sel == 3'd1);
  assign wr_status = wr_en && (reg_sel == 3'd3);
  assign en_rise   = wr_ctrl && bus.io_d_in[0] && !en_p1;

  assign unused_addr = &{1'b0, bus.io_address[31:5], bus.io_address[1:0]};

`ifdef IO_TIMER_PRESCALE_EN
  logic       wr_psc;
  logic [7:0] psc_p1;
  logic [7:0] psc_cnt_p1;

  assign wr_psc      = wr_en && (reg_sel == 3'd4);
  assign tick        = (psc_cnt_p1 == psc_p1);
  assign prescale_rd = {24'd0, psc_p1};

  // Prescale stage: one tick every PRESCALE+1 enabled cycles, phase restarts on enable
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_p1     <= 8'd0;
      psc_cnt_p1 <= 8'd0;
    end else begin
      if (wr_psc) begin
        psc_p1 <= bus.io_d_in[7:0];
      end
      if (en_rise) begin
        psc_cnt_p1 <= 8'd0;
      end else if (en_p1) begin
        psc_cnt_p1 <= tick ? 8'd0 : psc_cnt_p1 + 8'd1;
      end
    end
  end
`else
  assign tick        = 1'b1;
  assign prescale_rd = 32'd0;
`endif

  assign count_run = en_p1 && (period_p1 != 32'd0) && tick;
  assign timer_evt = count_run && (count_p1 == 32'd1);

  // Counter stage: a CTRL write wins over the event's EN clear, the event still fires
  always_ff @(posedge clk) begin
    if (reset) begin
      en_p1     <= 1'b0;
      auto_p1   <= 1'b0;
      period_p1 <= 32'd0;
      count_p1  <= 32'd0;
      evt_p1    <= 1'b0;
    end else begin
      evt_p1 <= timer_evt;
      if (wr_period) begin
        period_p1 <= bus.io_d_in;
      end
      if (en_rise) begin
        count_p1 <= period_p1;
      end else if (count_run) begin
        if (timer_evt) begin
          count_p1 <= auto_p1 ? period_p1 : 32'd0;
        end else if (count_p1 == 32'd0) begin
          count_p1 <= period_p1;
        end else begin
          count_p1 <= count_p1 - 32'd1;
        end
      end
      if (wr_ctrl) begin
        en_p1   <= bus.io_d_in[0];
        auto_p1 <= bus.io_d_in[1];
      end else if (timer_evt && !auto_p1) begin
        en_p1 <= 1'b0;
      end
    end
  end

  // Interrupt stage: acts on the registered event, so intr lags the count edge by one
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= S_IDLE;
      ovf_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (evt_p1 && (state_p1 != S_IDLE)) begin
        ovf_p1 <= 1'b1;
      end else if (wr_status && bus.io_d_in[1]) begin
        ovf_p1 <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      S_IDLE:  if (evt_p1)    state_nxt = S_REQ;
      S_REQ:   if (bus.inta)  state_nxt = S_ACK;
      S_ACK:   if (!bus.inta) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pend     = (state_p1 != S_IDLE);
  assign bus.intr = (state_p1 == S_REQ);

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      3'd0:    rdata = {30'd0, auto_p1, en_p1};
      3'd1:    rdata = period_p1;
      3'd2:    rdata = count_p1;
      3'd3:    rdata = {30'd0, ovf_p1, pend};
      3'd4:    rdata = prescale_rd;
      default: rdata = 32'd0;
    endcase
  end

  assign bus.io_out = rd_en ? rdata : 32'hZZZZ_ZZZZ;

endmodule

// File: doc/io_timer_intr.md
IO_TIMER_INTR -- requirements
Module: io_timer_intr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named clk and reset.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous active-high reset
- io_cs  in  1  IO chip select from CPU
- io_rd  in  1  IO read strobe
- io_wr  in  1  IO write strobe
- io_address  in  32  byte address; bits [4:2] select register
- io_d_in  in  32  CPU write data
- io_out  out  32  read data; high-Z when not (io_cs & io_rd)
- intr  out  1  interrupt request to CPU
- inta  in  1  interrupt acknowledge from CPU
REQ-003 The register map SHALL be: 0x00 CTRL (bit0 EN, bit1 AUTO), 0x04 PERIOD, 0x08 COUNT (read-only), 0x0C STATUS (bit0 PEND, bit1 OVF), 0x10 PRESCALE (bits [7:0]); other offsets read 0 and ignore writes.

Function
REQ-004 Reads SHALL be combinational: io_out = selected register while io_cs & io_rd, else 32'hZZZZZZZZ.
REQ-005 Writes SHALL take effect on the rising clk edge where io_cs & io_wr; io_rd & io_wr together SHALL be treated as a write, with io_out still driven.
REQ-006 A CTRL write with EN 0->1 SHALL load COUNT with PERIOD on the same edge.
REQ-007 While EN=1 and PERIOD!=0, COUNT SHALL decrement by 1 per tick; tick is every cycle (see REQ-016).
REQ-008 When COUNT decrements to 0 a timer event SHALL occur; on that edge COUNT reloads PERIOD if AUTO=1, else EN clears and COUNT holds 0.
REQ-009 PERIOD=0 SHALL stop counting and generate no events.
REQ-010 Interrupt FSM states: IDLE (intr=0), REQ (intr=1), ACK (intr=0, waiting for inta low); IDLE->REQ on event, registered so intr rises the cycle after the event edge.
REQ-011 REQ->ACK SHALL occur on the first edge sampling inta=1, with intr low the following cycle; ACK->IDLE on the first edge sampling inta=0.
REQ-012 STATUS.PEND SHALL equal 1 in REQ and ACK, else 0; it SHALL be read-only.
REQ-013 An event while in REQ or ACK SHALL set STATUS.OVF and SHALL NOT queue another request; writing 1 to STATUS bit1 clears OVF, and set wins over a simultaneous clear.
REQ-014 A CTRL write and an event on the same edge SHALL apply the CTRL write; the event is still signalled.
REQ-015 inta asserted while in IDLE SHALL be ignored.

Configuration
REQ-016 With IO_TIMER_PRESCALE_EN defined, an 8-bit prescale counter SHALL produce a tick every PRESCALE+1 cycles, reset on EN 0->1, and 0x10 SHALL be read/write; without it, tick SHALL be every cycle and 0x10 SHALL read 0 and ignore writes.

Reset
REQ-017 On reset=1 at a clk edge: CTRL, PERIOD, COUNT, STATUS, PRESCALE and prescale counter SHALL be 0, FSM SHALL be IDLE and intr SHALL be 0.
REQ-018 Reset SHALL override any simultaneous write, event or inta, including mid-handshake with intr high.
REQ-019 io_out SHALL stay combinational and high-Z during reset unless io_cs & io_rd.

Verification
REQ-020 Bench SHALL cover: PERIOD=5, CTRL=3 -> intr rises 6 cycles after the CTRL write edge and COUNT reads 5 again after the event.
REQ-021 Bench SHALL cover: while intr=1, pulse inta 1 cycle -> intr=0 next cycle, PEND=1 until inta low, then IDLE with PEND=0.
REQ-022 Bench SHALL cover: PERIOD=2, AUTO=1, CPU never acks -> OVF=1 after the second event; write STATUS=2 -> OVF=0 and intr still 1.
REQ-023 Bench SHALL cover: AUTO=0, PERIOD=3 -> one event, then CTRL reads 0 and COUNT reads 0.
REQ-024 Bench SHALL cover: reset asserted with intr=1 -> next cycle intr=0 and all registers read 0; with io_cs=0, io_out=Z.
REQ-025 Bench SHALL cover, with IO_TIMER_PRESCALE_EN defined: PRESCALE=3, PERIOD=2 -> event 8 cycles after enable; without the macro, 0x10 reads 0 after writing 0xFF.
